// File: rtl/serializer_stream_pkg.sv
// Shared types and helpers for the serializer_stream block.
//   word_t        : one accepted word (data, effective length, bit order)
//   state_t       : shifter FSM state
//   calc_eff_len  : maps the raw length field to the number of bits to send,
//                   returning 0 for an illegal length
// SER_DATA_W is the word width the struct is built for. The top-level DATA_W
// parameter defaults to it and must stay equal to it.
package serializer_stream_pkg;

  localparam int unsigned SER_DATA_W = 16;
  localparam int unsigned SER_LEN_W  = $clog2(SER_DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [SER_DATA_W-1:0] data;
    logic [SER_LEN_W:0]    eff_len;   // one extra bit so DATA_W itself fits
    logic                  msb_first;
  } word_t;

  // len==0 means a full word; 1..min_len-1 and >= data_w are illegal (0).
  function automatic logic [SER_LEN_W:0] calc_eff_len(
    input logic [SER_LEN_W-1:0] len,
    input int unsigned          data_w,
    input int unsigned          min_len
  );
    logic [SER_LEN_W:0] eff;
    eff = '0;
    if (len == '0)
      eff = (SER_LEN_W+1)'(data_w);
    else if (32'(len) >= min_len && 32'(len) < data_w)
      eff = {1'b0, len};
    return eff;
  endfunction

endpackage

// File: rtl/serializer_word_buf.sv
// One-word prefetch register with a full flag.
// Ports:
//   clk_i, arst_n_i : clock, async active-low reset
//   push_i          : store word_i (only issued while empty)
//   pop_i           : release the held word (only issued while full)
//   word_i / word_o : incoming / held word
//   full_o          : a word is held
module serializer_word_buf
  import serializer_stream_pkg::*;
(
  input  logic  clk_i,
  input  logic  arst_n_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  word_t word_i,
  output word_t word_o,
  output logic  full_o
);

  word_t word_q, word_d;
  logic  full_q, full_d;

  always_comb begin
    word_d = word_q;
    full_d = full_q;
    if (push_i) begin
      word_d = word_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign word_o = word_q;
  assign full_o = full_q;

endmodule

// File: rtl/serializer_stream.sv
// Parallel-to-serial converter with valid/ready on both sides. Each word
// carries its own length and bit order; illegal lengths are swallowed and
// flagged on drop_o for one cycle.
// Ports:
//   clk_i, arst_n_i                 : clock, async active-low reset
//   data_i, len_i, msb_first_i      : word, length (0 = DATA_W), order
//   data_val_i / data_rdy_o         : input handshake
//   ser_data_o, ser_data_val_o      : serial bit and its valid
//   ser_data_rdy_i                  : downstream accepts the current bit
//   ser_last_o                      : current bit ends its word
//   busy_o                          : a word is held (shifter or buffer)
//   drop_o                          : illegal-length word was discarded
// Optional: define SERIALIZER_PREFETCH_EN to add a one-word prefetch buffer
// so consecutive words stream without an idle cycle between them.
module serializer_stream
  import serializer_stream_pkg::*;
#(
  parameter int unsigned DATA_W  = SER_DATA_W,     // must equal SER_DATA_W
  parameter int unsigned LEN_W   = $clog2(DATA_W), // derived
  parameter int unsigned MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              msb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  input  logic              ser_data_rdy_i,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              drop_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_data_q, sh_data_d;
  logic              msb_q, msb_d;
  logic [LEN_W:0]    bits_left_q, bits_left_d;
  logic              drop_q, drop_d;

  word_t in_word, buf_word, ld_word;
  logic  buf_full, rdy_int;
  logic  acc, legal, ser_hs, last_hs, load;

  assign in_word = '{data: data_i,
                     eff_len: calc_eff_len(len_i, DATA_W, MIN_LEN),
                     msb_first: msb_first_i};
  assign legal   = (in_word.eff_len != '0);
  assign acc     = data_val_i && data_rdy_o;
  assign ser_hs  = (state_q == SHIFT) && ser_data_rdy_i;
  assign last_hs = ser_hs && (bits_left_q == (LEN_W+1)'(1));

`ifdef SERIALIZER_PREFETCH_EN
  logic buf_push, buf_pop;
  // A word arriving on the last-bit edge with the buffer empty bypasses the
  // buffer and goes straight into the shifter (see load path below).
  assign buf_push = acc && legal && (state_q == SHIFT) && !last_hs;
  assign buf_pop  = last_hs && buf_full;
  assign rdy_int  = !buf_full;

  serializer_word_buf u_word_buf (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (buf_push),
    .pop_i    (buf_pop),
    .word_i   (in_word),
    .word_o   (buf_word),
    .full_o   (buf_full)
  );
`else
  assign buf_full = 1'b0;
  assign buf_word = '0;
  assign rdy_int  = (state_q == IDLE);
`endif

  // Gated by reset so ready reads 0 while reset is held.
  assign data_rdy_o = arst_n_i && rdy_int;

  always_comb begin
    state_d     = state_q;
    sh_data_d   = sh_data_q;
    msb_d       = msb_q;
    bits_left_d = bits_left_q;
    load        = 1'b0;
    ld_word     = in_word;
    drop_d      = acc && !legal;

    case (state_q)
      IDLE: if (acc && legal) load = 1'b1;
      SHIFT: begin
        if (last_hs) begin
          if (buf_full) begin
            load    = 1'b1;
            ld_word = buf_word;
          end else if (acc && legal) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (ser_hs) begin
          sh_data_d   = msb_q ? (sh_data_q << 1) : (sh_data_q >> 1);
          bits_left_d = bits_left_q - (LEN_W+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = SHIFT;
      sh_data_d   = ld_word.data;
      msb_d       = ld_word.msb_first;
      bits_left_d = ld_word.eff_len;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      sh_data_q   <= '0;
      msb_q       <= 1'b0;
      bits_left_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_data_q   <= sh_data_d;
      msb_q       <= msb_d;
      bits_left_q <= bits_left_d;
      drop_q      <= drop_d;
    end
  end

  // All serial outputs come straight from flops, so they hold while stalled.
  assign ser_data_val_o = (state_q == SHIFT);
  assign ser_data_o     = (state_q == SHIFT) &&
                          (msb_q ? sh_data_q[DATA_W-1] : sh_data_q[0]);
  assign ser_last_o     = (state_q == SHIFT) && (bits_left_q == (LEN_W+1)'(1));
  assign busy_o         = (state_q == SHIFT) || buf_full;
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_serializer_stream.sv
// Directed + randomized bench for serializer_stream. A negedge monitor logs
// every transferred serial bit (value, last flag, cycle) and counts drop
// pulses; scenario tasks compare that log against hand-computed values.
module tb_serializer_stream;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] data_i;
  logic [3:0]  len_i;
  logic        msb_i, val_i, rdy_o;
  logic        ser_d, ser_v, ser_rdy, ser_last, busy, drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drop_cnt = 0;

  typedef struct {bit b; bit last; int c;} sbit_t;
  sbit_t mon_q[$];

  serializer_stream dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .data_i         (data_i),
    .len_i          (len_i),
    .msb_first_i    (msb_i),
    .data_val_i     (val_i),
    .data_rdy_o     (rdy_o),
    .ser_data_o     (ser_d),
    .ser_data_val_o (ser_v),
    .ser_data_rdy_i (ser_rdy),
    .ser_last_o     (ser_last),
    .busy_o         (busy),
    .drop_o         (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1ns after posedge, so negedge values decide the next edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (ser_v && ser_rdy) mon_q.push_back('{b: ser_d, last: ser_last, c: cyc});
      if (drop) drop_cnt <= drop_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Offer one word and hold it until accepted. Call 1ns after a posedge.
  task automatic send_word(input logic [15:0] d, input logic [3:0] l,
                           input logic m, output int acc_cyc);
    int n = 0;
    data_i = d; len_i = l; msb_i = m; val_i = 1'b1;
    @(negedge clk);
    while (!rdy_o && n < 200) begin n++; @(negedge clk); end
    if (!rdy_o) begin
      checks++; failures++;
      $display("FAIL send_timeout: data_rdy_o stayed 0 for word %h", d);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    val_i = 1'b0;
  endtask

  task automatic wait_bits(input int target);
    int n = 0;
    while (mon_q.size() < target && n < 100) begin @(posedge clk); n++; end
    #1;
  endtask

  task automatic test_reset();
    int base, acc;
    #1;
    if ({rdy_o, ser_d, ser_v, ser_last, busy, drop} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 000000",
                           {rdy_o, ser_d, ser_v, ser_last, busy, drop});
    end
    checks++;
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    #1;
    if (rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b want 1", rdy_o); end
    checks++;
    @(posedge clk); #1;
    ser_rdy = 1'b1;
    send_word(16'hA5C3, 4'd0, 1'b1, acc);
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    if ({rdy_o, ser_d, ser_v, ser_last, busy, drop} !== 6'b0) begin
      failures++; $display("FAIL reset_midword: got %b want 000000",
                           {rdy_o, ser_d, ser_v, ser_last, busy, drop});
    end
    checks++;
    #10 arst_n = 1'b1;
    #1;
    if (rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy2: got %b want 1", rdy_o); end
    checks++;
    base = mon_q.size();
    repeat (20) @(posedge clk);
    #1;
    if (mon_q.size() != base || busy !== 1'b0) begin
      failures++; $display("FAIL reset_abort: extra bits %0d busy %b want 0 0",
                           mon_q.size() - base, busy);
    end
    checks++;
  endtask

  task automatic test_msb_full();
    int base, acc;
    logic [15:0] bits, lasts;
    base = mon_q.size();
    ser_rdy = 1'b1;
    send_word(16'hA5C3, 4'd0, 1'b1, acc);
    wait_bits(base + 16);
    if (mon_q.size() != base + 16) begin
      failures++; $display("FAIL msb_count: got %0d want 16", mon_q.size() - base);
    end
    checks++;
    bits = '0; lasts = '0;
    for (int i = 0; i < 16 && base + i < mon_q.size(); i++) begin
      bits  = {bits[14:0], mon_q[base+i].b};
      lasts = {lasts[14:0], mon_q[base+i].last};
    end
    if (bits !== 16'hA5C3) begin failures++; $display("FAIL msb_bits: got %h want a5c3", bits); end
    checks++;
    if (lasts !== 16'h0001) begin failures++; $display("FAIL msb_last: got %h want 0001", lasts); end
    checks++;
    if (mon_q.size() > base && mon_q[base].c != acc + 1) begin
      failures++; $display("FAIL msb_latency: first bit cycle %0d want %0d", mon_q[base].c, acc + 1);
    end
    checks++;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_lsb_drop();
    int base, acc, d0;
    logic [4:0] bits, lasts;
    base = mon_q.size();
    send_word(16'h0001, 4'd5, 1'b0, acc);
    wait_bits(base + 5);
    bits = '0; lasts = '0;
    for (int i = 0; i < 5 && base + i < mon_q.size(); i++) begin
      bits  = {bits[3:0], mon_q[base+i].b};
      lasts = {lasts[3:0], mon_q[base+i].last};
    end
    if (bits !== 5'b10000 || lasts !== 5'b00001) begin
      failures++; $display("FAIL lsb_bits: got %b/%b want 10000/00001", bits, lasts);
    end
    checks++;
    repeat (3) @(posedge clk); #1;
    base = mon_q.size();
    d0 = drop_cnt;
    send_word(16'hFFFF, 4'd1, 1'b1, acc);
    send_word(16'hFFFF, 4'd2, 1'b0, acc);
    repeat (5) @(posedge clk); #1;
    if (drop_cnt - d0 != 2) begin
      failures++; $display("FAIL drop_count: got %0d want 2", drop_cnt - d0);
    end
    checks++;
    if (mon_q.size() != base || busy !== 1'b0) begin
      failures++; $display("FAIL drop_nobits: bits %0d busy %b want 0 0", mon_q.size() - base, busy);
    end
    checks++;
  endtask

  task automatic test_stall();
    int base, acc;
    bit pat[7]      = '{1, 0, 0, 1, 1, 0, 1};
    bit exp_last[7] = '{0, 0, 0, 0, 0, 1, 1};
    base = mon_q.size();
    ser_rdy = 1'b0;
    send_word(16'hFFFF, 4'd4, 1'b1, acc);
    for (int i = 0; i < 7; i++) begin
      ser_rdy = pat[i];
      @(negedge clk);
      if ({ser_v, ser_d, ser_last, busy} !== {3'b111 & {2'b11, exp_last[i]}, 1'b1}) begin
        failures++; $display("FAIL stall_hold[%0d]: val/data/last/busy %b want 11%0d1",
                             i, {ser_v, ser_d, ser_last, busy}, exp_last[i]);
      end
      checks++;
      @(posedge clk); #1;
    end
    ser_rdy = 1'b1;
    @(negedge clk);
    if (ser_v !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stall_busy_fall: val %b busy %b want 0 0", ser_v, busy);
    end
    checks++;
    if (mon_q.size() != base + 4) begin
      failures++; $display("FAIL stall_count: got %0d want 4", mon_q.size() - base);
    end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int base, acc, gap;
    logic [11:0] bits, lasts;
`ifdef SERIALIZER_PREFETCH_EN
    int exp_gap = 1;
`else
    int exp_gap = 2;
`endif
    base = mon_q.size();
    ser_rdy = 1'b1;
    send_word(16'h00F0, 4'd8, 1'b1, acc);
    send_word(16'h000F, 4'd4, 1'b0, acc);
    wait_bits(base + 12);
    bits = '0; lasts = '0;
    for (int i = 0; i < 12 && base + i < mon_q.size(); i++) begin
      bits  = {bits[10:0], mon_q[base+i].b};
      lasts = {lasts[10:0], mon_q[base+i].last};
    end
    if (bits !== 12'b0000_0000_1111 || lasts !== 12'b0000_0001_0001) begin
      failures++; $display("FAIL b2b_bits: got %b/%b want 000000001111/000000010001", bits, lasts);
    end
    checks++;
    gap = (mon_q.size() >= base + 12) ? mon_q[base+8].c - mon_q[base+7].c : -1;
    if (gap != exp_gap) begin
      failures++; $display("FAIL b2b_gap: got %0d want %0d", gap, exp_gap);
    end
    checks++;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_random();
    sbit_t exp_q[$];
    int base, d0, acc, eff, n_ill, errs;
    logic [15:0] d;
    logic [3:0]  l;
    logic        m;
    bit          done;
    base = mon_q.size(); d0 = drop_cnt; n_ill = 0; errs = 0; done = 0;
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          d = 16'($urandom);
          l = 4'($urandom_range(0, 15));
          m = 1'($urandom_range(0, 1));
          eff = (l == 0) ? 16 : ((l >= 3) ? int'(l) : 0);
          if (eff == 0) n_ill++;
          for (int k = 0; k < eff; k++)
            exp_q.push_back('{b: m ? d[15-k] : d[k], last: (k == eff - 1), c: 0});
          send_word(d, l, m, acc);
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ser_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ser_rdy = 1'b1;
    wait_bits(base + exp_q.size());
    repeat (3) @(posedge clk); #1;
    if (mon_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d want %0d", mon_q.size() - base, exp_q.size());
    end
    checks++;
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++)
      if (mon_q[base+i].b != exp_q[i].b || mon_q[base+i].last != exp_q[i].last) errs++;
    if (errs != 0) begin
      failures++; $display("FAIL rand_stream: %0d bit errors want 0", errs);
    end
    checks++;
    if (drop_cnt - d0 != n_ill) begin
      failures++; $display("FAIL rand_drops: got %0d want %0d", drop_cnt - d0, n_ill);
    end
    checks++;
  endtask

  initial begin
    arst_n = 1'b0; data_i = '0; len_i = '0; msb_i = 1'b0; val_i = 1'b0; ser_rdy = 1'b0;
    test_reset();
    test_msb_full();
    test_lsb_drop();
    test_stall();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parametrised parallel-to-serial converter with a valid/ready handshake on both sides. Each accepted word carries its own bit count and bit-order select. Output backpressure stalls the shifter, and words with illegal lengths are discarded and flagged. Sits between parallel producers (packetisers, register blocks) and single-bit line drivers.

Parameters:
DATA_W, 16, parallel word width in bits; must be >= 4.
LEN_W, $clog2(DATA_W), width of the length field; derived, do not override.
MIN_LEN, 3, smallest legal nonzero length; 1..MIN_LEN-1 are illegal.

Ports:
clk_i  in  1  clock, rising edge
arst_n_i  in  1  asynchronous active-low reset
data_i  in  DATA_W  parallel word
len_i  in  LEN_W  bits to send; 0 means DATA_W
msb_first_i  in  1  1: send MSB first; 0: send LSB first
data_val_i  in  1  input word valid
data_rdy_o  out  1  block can accept a word
ser_data_o  out  1  serial bit
ser_data_val_o  out  1  serial bit valid
ser_data_rdy_i  in  1  downstream accepts the current bit
ser_last_o  out  1  current bit is the last of its word
busy_o  out  1  a word is held (shifter or prefetch buffer)
drop_o  out  1  one-cycle pulse: an illegal-length word was discarded

Behaviour:
- Reset: clk_i single clock; arst_n_i asynchronous active-low. Assertion immediately clears all outputs to 0, clears state to IDLE, and discards any held words. No partial word resumes. On deassertion, data_rdy_o becomes 1 combinationally from IDLE.
- Effective length L: len_i==0 gives DATA_W; MIN_LEN <= len_i <= DATA_W-1 gives len_i; otherwise the length is illegal.
- Input handshake: a word transfers on a rising edge with data_val_i && data_rdy_o. data_i, len_i and msb_first_i are sampled only at that edge.
- Illegal-length word: it is accepted (it consumes the handshake) but is never stored. drop_o = 1 for exactly the next cycle, and state is unchanged.
- Legal word in IDLE: loaded into the shifter. First bit appears with ser_data_val_o = 1 in the next cycle (1-cycle latency).
- Bit order:
  - msb_first=1: bits data[DATA_W-1] down to data[DATA_W-L].
  - msb_first=0: bits data[0] up to data[L-1].
- Output handshake: a bit transfers on an edge with ser_data_val_o && ser_data_rdy_i.
  - While ser_data_rdy_i = 0, ser_data_o, ser_data_val_o and ser_last_o hold unchanged.
  - Valid never drops mid-word.
- ser_last_o = 1 only together with the L-th bit of a word.
- FSM states:
  - IDLE: busy=0, val=0. A legal accept moves to SHIFT.
  - SHIFT: down-counter bits_left (LEN_W+1 bits) is loaded with L and decremented on each output handshake.
  - On the last-bit handshake: go to IDLE if no next word is available; otherwise load the next word and stay in SHIFT.
- Ready without prefetch: data_rdy_o = (state==IDLE). Consecutive words therefore have one idle cycle between the last bit of one and the first bit of the next.
- busy_o = (state==SHIFT) || prefetch buffer full. It drops in the cycle after the last-bit handshake when nothing is pending.
- ser_data_o = 0 whenever ser_data_val_o = 0.

Optional Feature:
SERIALIZER_PREFETCH_EN
- Defined: a one-word prefetch buffer is added.
  - data_rdy_o = !buffer_full; in SHIFT, a legal word accepted goes to the buffer.
  - On the last-bit handshake with the buffer full, the buffer word loads into the shifter on the same edge. Back-to-back words then stream with zero gap.
  - If a word is accepted on that same edge while the buffer is empty, the new word loads directly into the shifter.
- Undefined: no buffer; ready/gap behaviour is as described above.

Decomposition:
- serializer_stream_pkg holds:
  - typedef struct word_t {data, eff_len, msb_first}.
  - Function calc_eff_len(len, DATA_W, MIN_LEN), returning 0 when illegal.
  - typedef enum state_t {IDLE, SHIFT}.
- One sub-module, serializer_word_buf: the prefetch register with full flag, instantiated only under SERIALIZER_PREFETCH_EN.

Test Plan:
1. Reset: hold arst_n_i=0 for 2 cycles, then assert it again mid-word -> all outputs 0 immediately, data_rdy_o=1 after release, no further bits from the aborted word.
2. data=16'hA5C3, len=0, msb_first=1, ready tied 1 -> 16 bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; first bit 1 cycle after accept; ser_last_o only on bit 16.
3. data=16'h0001, len=5, msb_first=0 -> bits 1,0,0,0,0; then len=1 and len=2 words -> accepted, drop_o pulses once each, no serial output.
4. data=16'hFFFF, len=4, ser_data_rdy_i toggling 1,0,0,1,1,0,1 -> exactly 4 bits transferred, outputs held while stalled, busy_o falls 1 cycle after last handshake.
5. Two words 16'h00F0/len=8/msb and 16'h000F/len=4/lsb offered continuously -> without macro: 1 idle cycle between words; with SERIALIZER_PREFETCH_EN: 12 consecutive valid bits, no gap.
6. 1000 random words (random len, order, stall pattern) -> scoreboard matches the bit stream; drop count equals the number of illegal lengths.
